aes_sc_host: RTL

//  Host-side initiator for the aes_if scan-chain interface. Assembles the 387-bit

---
 rtl/aes_sc_host_pkg.sv | 24 ++
 rtl/aes_sc_ct_serializer.sv | 53 +++++
 rtl/aes_sc_host.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/aes_sc_host_pkg.sv
// Shared types and constants for the aes_if scan-chain host.
// Field offsets describe the 387-bit scan vector layout.
`timescale 1ns/1ps
package aes_sc_host_pkg;

    typedef enum logic [1:0] {
        LOAD,
        READY,
        RUN,
        UNLOAD
    } state_t;

    localparam int SC_BYTES = 49;
    localparam int CT_BYTES = 16;
    localparam int PAD_BITS = 5;
    localparam int SR_W     = SC_BYTES * 8;

    localparam int PT_LSB   = 259;
    localparam int KEY_LSB  = 3;
    localparam int PT_SEL   = 2;
    localparam int KEY_SEL  = 1;
    localparam int CT_SEL   = 0;

endpackage

// File: rtl/aes_sc_ct_serializer.sv
// Holds the captured ciphertext and hands it out one byte at a time,
// MSB first, over a valid/ready port.
`timescale 1ns/1ps
module aes_sc_ct_serializer #(
    parameter int CT_W = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            load,
    input  logic [CT_W-1:0] ct,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [7:0]      rd_data,
    output logic            rd_last
);

    localparam int NB = CT_W / 8;
    localparam int CW = $clog2(NB);

    logic [CT_W-1:0] sr;
    logic [CW-1:0]   cnt;
    logic            fire;

    assign fire    = rd_valid & rd_ready;
    assign rd_last = fire & (cnt == CW'(NB - 1));
    assign rd_data = sr[CT_W-1 -: 8];

    // Load on capture, shift one byte per handshake, stop after the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '0;
            cnt      <= '0;
            rd_valid <= 1'b0;
        end else if (clear) begin
            cnt      <= '0;
            rd_valid <= 1'b0;
        end else if (load) begin
            sr       <= ct;
            cnt      <= '0;
            rd_valid <= 1'b1;
        end else if (fire) begin
            sr <= {sr[CT_W-9:0], 8'h00};
            if (rd_last) begin
                cnt      <= '0;
                rd_valid <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_sc_host.sv
// Host-side initiator for the aes_if scan chain: load, run, unload.
// Optional RUN watchdog and err port: define AES_SC_HOST_TIMEOUT_EN.
`timescale 1ns/1ps
module aes_sc_host
    import aes_sc_host_pkg::*;
#(
    parameter int SC_W           = 387,
    parameter int CT_W           = 128,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [7:0]      wr_data,
    input  logic            start,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [7:0]      rd_data,
    output logic            busy,
    output logic            done,
`ifdef AES_SC_HOST_TIMEOUT_EN
    output logic            err,
`endif
    output logic [SC_W-1:0] scan_chain,
    output logic            enable,
    input  logic            trigger,
    input  logic [SC_W-1:0] sc_out
);

    state_t          state;
    state_t          state_n;
    logic [5:0]      byte_cnt;
    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] sr_n;
    logic            trigger_q;
    logic            edge_det;
    logic            wr_fire;
    logic            load_done;
    logic            capture;
    logic            rd_last;
    logic            timeout;
    logic            unused_bits;

    assign edge_det  = trigger & ~trigger_q;
    assign wr_fire   = (state == LOAD) & wr_valid;
    assign load_done = wr_fire & (byte_cnt == 6'(SC_BYTES - 1));
    assign capture   = (state == RUN) & edge_det & ~clear;
    assign sr_n      = {sr[SR_W-9:0], wr_data};

    // Pad bits and the unused upper scan-out bits are intentionally dropped.
    assign unused_bits = ^{sr[SR_W-1:SR_W-8], sr_n[SR_W-1:SC_W],
                           sc_out[SC_W-1:CT_W]};

`ifdef AES_SC_HOST_TIMEOUT_EN
    logic [15:0] tcnt;

    assign timeout = (state == RUN) & ~edge_det &
                     (tcnt == 16'(TIMEOUT_CYCLES - 1));

    // Watchdog counts RUN cycles and restarts whenever RUN is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
        end else if (state == RUN && !clear) begin
            tcnt <= tcnt + 16'd1;
        end else begin
            tcnt <= '0;
        end
    end

    // One-cycle error pulse when the watchdog expires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= timeout & ~clear;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; clear overrides every other event.
    always_comb begin
        state_n = state;
        if (clear) begin
            state_n = LOAD;
        end else begin
            unique case (state)
                LOAD:   if (load_done) state_n = READY;
                READY:  if (start) state_n = RUN;
                RUN: begin
                    if (edge_det) begin
                        state_n = UNLOAD;
                    end else if (timeout) begin
                        state_n = LOAD;
                    end
                end
                UNLOAD: if (rd_last) state_n = LOAD;
                default: state_n = LOAD;
            endcase
        end
    end

    // State-decoded outputs; enable follows the async-reset state.
    always_comb begin
        wr_ready = (state == LOAD);
        enable   = (state == RUN);
        busy     = (state == RUN);
    end

    // Byte stream assembly into the scan vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt   <= '0;
            sr         <= '0;
            scan_chain <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (wr_fire) begin
            sr <= sr_n;
            if (load_done) begin
                byte_cnt   <= '0;
                scan_chain <= sr_n[SC_W-1:0];
            end else begin
                byte_cnt <= byte_cnt + 6'd1;
            end
        end
    end

    // Trigger history for rising-edge detection, and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trigger_q <= 1'b0;
            done      <= 1'b0;
        end else begin
            trigger_q <= trigger;
            done      <= capture;
        end
    end

    aes_sc_ct_serializer #(
        .CT_W (CT_W)
    ) u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .load     (capture),
        .ct       (sc_out[CT_W-1:0]),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_last  (rd_last)
    );

endmodule
